deser_arbiter: RTL and testbench
================================

// Module: deser_arbiter
// PURPOSE
//  Shares one deserializador instance among N_SRC serial bit sources. Grants round-robin, forwards the
//  granted source's bit/strobe for exactly 8 writes, runs the ready/ack handshake with the deserializer,
//  and presents each byte tagged with its source id on a valid/ready output. Sits between serial senders and byte consumer.
// PARAMETERS
//  N_SRC      4   number of serial requesters (>=2)
//  SRC_W      $clog2(N_SRC)  width of source id
//  TIMEOUT    32  max cycles in WAIT_RDY before abort
// PORTS
//  clk_100KHz       in   1      clock
//  reset            in   1      async, active-high
//  req              in   N_SRC  per-source request, level
//  src_data         in   N_SRC  per-source serial bit
//  src_write        in   N_SRC  per-source bit strobe
//  gnt              out  N_SRC  one-hot grant, registered
//  deser_data_in    out  1      to deserializer data_in
//  deser_write_in   out  1      to deserializer write_in
//  deser_ack_in     out  1      to deserializer ack_in, registered
//  deser_data_ready in   1      from deserializer data_ready
//  deser_data_out   in   8      from deserializer data_out
//  out_valid        out  1      byte available
//  out_ready        in   1      consumer accepts
//  out_data         out  8      captured byte
//  out_src          out  SRC_W  id of source that sent out_data
//  err_timeout      out  1      sticky, cleared only by reset
// BEHAVIOUR
//  Reset: reset, asynchronous, active-high; clock clk_100KHz. All outputs 0, state IDLE, last_gnt=N_SRC-1, bit_cnt=0.
//  FSM IDLE -> SHIFT -> WAIT_RDY -> ACK -> IDLE.
//  IDLE: if |req, pick first set req searching from last_gnt+1 with wrap; latch cur, gnt<=onehot(cur) -> SHIFT.
//    No req: stay. Latency req->gnt: 1 cycle.
//  SHIFT: deser_data_in=src_data[cur], deser_write_in=src_write[cur] (combinational, gated by state).
//    bit_cnt++ per forwarded strobe; on the 8th strobe gnt<=0, bit_cnt<=0 -> WAIT_RDY.
//    Strobes after the 8th are never forwarded. req[cur] dropped mid-byte: ignored, grant held until 8 bits.
//    Strobes from non-granted sources: ignored.
//  WAIT_RDY: wait deser_data_ready=1 and output slot free (out_valid=0, or out_ready=1 this cycle).
//    Then out_data<=deser_data_out, out_src<=cur, out_valid<=1, deser_ack_in<=1 -> ACK.
//    If data_ready=1 but slot full: stay (backpressure), timer frozen.
//    timer counts only while data_ready=0; timer==TIMEOUT -> err_timeout<=1, last_gnt<=cur -> IDLE, byte lost.
//  ACK: hold deser_ack_in=1 until deser_data_ready observed 0. Then deser_ack_in<=0, last_gnt<=cur -> IDLE.
//    Ack is held at least 2 cycles, so the deserializer clears and does not re-present the byte.
//  Output: out_valid held with out_data/out_src stable until out_ready=1. Accept and new capture
//    in same cycle allowed: new byte loads, out_valid stays 1.
//  Throughput: next grant issued the cycle after returning to IDLE; no grant overlaps WAIT_RDY/ACK.
//  Fairness: a source that just completed is lowest priority next arbitration.
//  Reset mid-operation: everything returns to reset values immediately; partial byte discarded here.
//    The deserializer shares the same reset.
// STRUCTURE
//  Package deser_arb_pkg: typedef enum logic [1:0] {IDLE, SHIFT, WAIT_RDY, ACK} arb_state_t;
//    localparam BITS_PER_BYTE = 8.
//  Sub-module rr_picker #(N_SRC): combinational; inputs req, last_gnt; outputs any, idx.
//  Top holds FSM, bit_cnt[3:0], timeout counter, output register.
// TESTING (bench instantiates deser_arbiter + deserializador)
//  1 req=0001, src0 sends 8'hA5 MSB first -> out_valid=1, out_data=A5, out_src=0; ack pulse >=2 cycles; back to IDLE.
//  2 req=1111 held; each source sends its index byte -> out_src order 0,1,2,3,0; no source granted twice in a row.
//  3 src1 issues 10 strobes in its grant -> exactly 8 forwarded; out_data = first 8 bits; extra 2 ignored.
//  4 out_ready=0 during two bytes (3C then C3) -> 3C held stable, FSM parks in WAIT_RDY.
//    out_ready=1 -> 3C then C3 delivered, none lost.
//  5 Deserializer data_ready forced 0 after 8 bits -> after 32 cycles err_timeout=1, FSM IDLE,
//    next request granted; err stays 1.
//  6 reset asserted after 4 bits of src2 -> gnt=0, out_valid=0, deser_ack_in=0 immediately.
//    Next byte after release is received intact.

Source files
------------

// File: rtl/deser_arb_pkg.sv
// rtl/deser_arb_pkg.sv - shared types and constants for the deserializer arbiter
package deser_arb_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_RDY, ACK} arb_state_t;

   localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/deser_arbiter_if.sv
// rtl/deser_arbiter_if.sv - source, deserializer and byte-output signals of the arbiter
interface deser_arbiter_if #(
   parameter int N_SRC = 4,
   parameter int SRC_W = $clog2(N_SRC)
);

   logic [N_SRC-1:0] req;
   logic [N_SRC-1:0] src_data;
   logic [N_SRC-1:0] src_write;
   logic [N_SRC-1:0] gnt;
   logic             deser_data_in;
   logic             deser_write_in;
   logic             deser_ack_in;
   logic             deser_data_ready;
   logic [7:0]       deser_data_out;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic [SRC_W-1:0] out_src;
   logic             err_timeout;

   // slave is the arbiter itself; master is everything around it
   modport slave (
      input  req, src_data, src_write, deser_data_ready, deser_data_out, out_ready,
      output gnt, deser_data_in, deser_write_in, deser_ack_in,
             out_valid, out_data, out_src, err_timeout
   );

   modport master (
      output req, src_data, src_write, deser_data_ready, deser_data_out, out_ready,
      input  gnt, deser_data_in, deser_write_in, deser_ack_in,
             out_valid, out_data, out_src, err_timeout
   );

endinterface

// File: rtl/deser_arbiter_rr_picker.sv
// rtl/deser_arbiter_rr_picker.sv - combinational round-robin pick starting after last_gnt
module rr_picker #(
   parameter int N_SRC = 4,
   parameter int SRC_W = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [SRC_W-1:0] last_gnt,
   output logic             any,
   output logic [SRC_W-1:0] idx
);

   logic [SRC_W-1:0] cand;

   // Walk from farthest to nearest so the closest requester after last_gnt wins.
   always_comb begin
      any  = |req;
      idx  = '0;
      cand = '0;
      for (int k = N_SRC; k >= 1; k--) begin
         cand = SRC_W'((int'(last_gnt) + k) % N_SRC);
         if (req[cand]) begin
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/deser_arbiter.sv
// rtl/deser_arbiter.sv - round-robin sharing of one deserializer among N_SRC serial sources
module deser_arbiter
   import deser_arb_pkg::*;
#(
   parameter int N_SRC   = 4,
   parameter int SRC_W   = $clog2(N_SRC),
   parameter int TIMEOUT = 32
) (
   input  logic           clk_100KHz,
   input  logic           reset,
   deser_arbiter_if.slave bus
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   arb_state_t       state;
   arb_state_t       state_next;
   logic [SRC_W-1:0] cur;
   logic [SRC_W-1:0] last_gnt;
   logic [3:0]       bit_cnt;
   logic [TMR_W-1:0] timer;
   logic             ack_seen;

   logic             pick_any;
   logic [SRC_W-1:0] pick_idx;
   logic             fwd_write;
   logic             last_bit;
   logic             slot_free;
   logic             capture;
   logic             timed_out;
   logic             ack_done;

   rr_picker #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_picker (
      .req      (bus.req),
      .last_gnt (last_gnt),
      .any      (pick_any),
      .idx      (pick_idx)
   );

   assign fwd_write = bus.deser_write_in;
   assign last_bit  = fwd_write && (bit_cnt == 4'(BITS_PER_BYTE - 1));
   assign slot_free = !bus.out_valid || bus.out_ready;
   assign capture   = (state == WAIT_RDY) && bus.deser_data_ready && slot_free;
   assign timed_out = (state == WAIT_RDY) && !bus.deser_data_ready && (timer == TMR_W'(TIMEOUT));
   // ack_seen guarantees ack stays up for two cycles even if data_ready drops early
   assign ack_done  = (state == ACK) && ack_seen && !bus.deser_data_ready;

   always_ff @(posedge clk_100KHz or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (pick_any) state_next = SHIFT;
         SHIFT:    if (last_bit) state_next = WAIT_RDY;
         WAIT_RDY: begin
            if (capture)        state_next = ACK;
            else if (timed_out) state_next = IDLE;
         end
         ACK:      if (ack_done) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.deser_data_in  = 1'b0;
      bus.deser_write_in = 1'b0;
      if (state == SHIFT) begin
         bus.deser_data_in  = bus.src_data[cur];
         bus.deser_write_in = bus.src_write[cur];
      end
   end

   always_ff @(posedge clk_100KHz or posedge reset) begin
      if (reset) begin
         cur              <= '0;
         last_gnt         <= SRC_W'(N_SRC - 1);
         bit_cnt          <= '0;
         timer            <= '0;
         ack_seen         <= 1'b0;
         bus.gnt          <= '0;
         bus.deser_ack_in <= 1'b0;
         bus.out_valid    <= 1'b0;
         bus.out_data     <= '0;
         bus.out_src      <= '0;
         bus.err_timeout  <= 1'b0;
      end else begin
         if (state == IDLE && pick_any) begin
            cur     <= pick_idx;
            bus.gnt <= N_SRC'(1) << pick_idx;
         end

         if (fwd_write) begin
            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
         end
         if (last_bit) begin
            bus.gnt <= '0;
         end

         // timer only advances while the deserializer has nothing to present
         if (state != WAIT_RDY) begin
            timer <= '0;
         end else if (!bus.deser_data_ready && !timed_out) begin
            timer <= timer + TMR_W'(1);
         end

         if (capture) begin
            bus.out_data     <= bus.deser_data_out;
            bus.out_src      <= cur;
            bus.out_valid    <= 1'b1;
            bus.deser_ack_in <= 1'b1;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end

         if (timed_out) begin
            bus.err_timeout <= 1'b1;
            last_gnt        <= cur;
         end

         ack_seen <= (state == ACK) && !ack_done;
         if (ack_done) begin
            bus.deser_ack_in <= 1'b0;
            last_gnt         <= cur;
         end
      end
   end

endmodule

// File: tb/tb_deser_arbiter.sv
// tb/tb_deser_arbiter.sv - directed bench for deser_arbiter with a behavioural deserializer
module tb_deser_arbiter;

   localparam int N_SRC   = 4;
   localparam int SRC_W   = 2;
   localparam int TIMEOUT = 32;

   logic clk_100KHz = 1'b0;
   logic reset      = 1'b1;
   logic block_rdy  = 1'b0;

   always #5 clk_100KHz = ~clk_100KHz;

   deser_arbiter_if #(.N_SRC(N_SRC), .SRC_W(SRC_W)) bus ();

   deser_arbiter #(.N_SRC(N_SRC), .SRC_W(SRC_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_100KHz (clk_100KHz),
      .reset      (reset),
      .bus        (bus)
   );

   // Deserializer model: MSB first, holds the byte until acked; block_rdy loses the byte.
   logic [7:0] ds_shift, ds_out;
   logic [2:0] ds_cnt;
   logic       ds_rdy;

   always_ff @(posedge clk_100KHz or posedge reset) begin
      if (reset) begin
         ds_shift <= '0;
         ds_out   <= '0;
         ds_cnt   <= '0;
         ds_rdy   <= 1'b0;
      end else if (ds_rdy && bus.deser_ack_in) begin
         ds_rdy <= 1'b0;
      end else if (!ds_rdy && bus.deser_write_in) begin
         ds_shift <= {ds_shift[6:0], bus.deser_data_in};
         if (ds_cnt == 3'd7) begin
            ds_cnt <= '0;
            if (!block_rdy) begin
               ds_out <= {ds_shift[6:0], bus.deser_data_in};
               ds_rdy <= 1'b1;
            end
         end else begin
            ds_cnt <= ds_cnt + 3'd1;
         end
      end
   end

   assign bus.deser_data_ready = ds_rdy;
   assign bus.deser_data_out   = ds_out;

   logic [7:0]       got_data[$];
   logic [SRC_W-1:0] got_src[$];
   int               ack_run      = 0;
   int               last_ack_run = 0;
   int               fwd_total    = 0;

   always @(negedge clk_100KHz) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         got_data.push_back(bus.out_data);
         got_src.push_back(bus.out_src);
      end
      if (bus.deser_write_in) fwd_total <= fwd_total + 1;
      if (bus.deser_ack_in) begin
         ack_run <= ack_run + 1;
      end else if (ack_run > 0) begin
         last_ack_run <= ack_run;
         ack_run      <= 0;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_100KHz);
      #1;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.req       = '0;
      bus.src_data  = '0;
      bus.src_write = '0;
      block_rdy     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic wait_gnt(input int src, input int budget);
      bit ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (bus.gnt[src]) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check($sformatf("gnt%0d_wait", src), 32'(ok), 32'd1);
   endtask

   task automatic wait_any_gnt(input int budget, output int idx);
      idx = -1;
      for (int k = 0; k < budget && idx < 0; k++) begin
         for (int s = 0; s < N_SRC; s++) if (bus.gnt[s]) idx = s;
         if (idx < 0) tick();
      end
      check("any_gnt_wait", 32'(idx >= 0), 32'd1);
      if (idx < 0) idx = 0;
   endtask

   task automatic wait_bytes(input int target, input int budget);
      for (int k = 0; k < budget && got_data.size() < target; k++) tick();
      check("byte_wait", 32'(got_data.size() >= target), 32'd1);
   endtask

   task automatic send_bits(input int src, input logic [9:0] bits, input int n, input bit drop_req);
      wait_gnt(src, 60);
      if (drop_req) bus.req[src] = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.src_data[src]  = bits[9-i];
         bus.src_write[src] = 1'b1;
         tick();
      end
      bus.src_write[src] = 1'b0;
      bus.src_data[src]  = 1'b0;
   endtask

   typedef struct {
      int         src;
      logic [9:0] bits;
      int         nbits;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int base;
      int fwd0;
      int idx;
      int n;
      int order[5];
      int exp_order[5];

      vecs[0] = '{0, {8'hA5, 2'b00}, 8,  8'hA5};
      vecs[1] = '{1, 10'b1100101011, 10, 8'hCA};
      vecs[2] = '{3, {8'h00, 2'b00}, 8,  8'h00};
      vecs[3] = '{2, {8'hFF, 2'b00}, 8,  8'hFF};
      vecs[4] = '{0, {8'h5A, 2'b11}, 10, 8'h5A};
      exp_order = '{0, 1, 2, 3, 0};

      bus.req       = '0;
      bus.src_data  = '0;
      bus.src_write = '0;
      bus.out_ready = 1'b1;
      tick();
      check("rst_gnt",       32'(bus.gnt),            32'd0);
      check("rst_ack",       32'(bus.deser_ack_in),   32'd0);
      check("rst_valid",     32'(bus.out_valid),      32'd0);
      check("rst_data",      32'(bus.out_data),       32'd0);
      check("rst_src",       32'(bus.out_src),        32'd0);
      check("rst_err",       32'(bus.err_timeout),    32'd0);
      check("rst_write_out", 32'(bus.deser_write_in), 32'd0);
      do_reset();

      // single-source bytes, including over-long strobe bursts
      for (int v = 0; v < 5; v++) begin
         base = got_data.size();
         fwd0 = fwd_total;
         bus.req[vecs[v].src] = 1'b1;
         send_bits(vecs[v].src, vecs[v].bits, vecs[v].nbits, 1'b1);
         wait_bytes(base + 1, 60);
         repeat (6) tick();
         check($sformatf("v%0d_data", v), 32'(got_data[base]), 32'(vecs[v].exp_data));
         check($sformatf("v%0d_src", v),  32'(got_src[base]),  32'(vecs[v].src));
         check($sformatf("v%0d_count", v), 32'(got_data.size() - base), 32'd1);
         check($sformatf("v%0d_fwd", v),  32'(fwd_total - fwd0), 32'd8);
         check($sformatf("v%0d_ack_len", v), 32'(last_ack_run >= 2), 32'd1);
         check($sformatf("v%0d_ack_idle", v), 32'(bus.deser_ack_in), 32'd0);
         check($sformatf("v%0d_gnt_idle", v), 32'(bus.gnt), 32'd0);
      end

      // all four requesting: strict rotation, wrap back to 0
      do_reset();
      base = got_data.size();
      bus.req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_any_gnt(60, idx);
         order[g] = idx;
         if (g == 4) bus.req = '0;
         send_bits(idx, {8'(idx), 2'b00}, 8, 1'b0);
      end
      wait_bytes(base + 5, 80);
      for (int g = 0; g < 5; g++) begin
         check($sformatf("rr_order%0d", g), 32'(order[g]), 32'(exp_order[g]));
         check($sformatf("rr_src%0d", g),   32'(got_src[base+g]),  32'(exp_order[g]));
         check($sformatf("rr_data%0d", g),  32'(got_data[base+g]), 32'(exp_order[g]));
      end

      // backpressure: second byte parks in WAIT_RDY until the consumer drains the first
      do_reset();
      base = got_data.size();
      bus.out_ready = 1'b0;
      bus.req = 4'b0011;
      send_bits(0, {8'h3C, 2'b00}, 8, 1'b1);
      send_bits(1, {8'hC3, 2'b00}, 8, 1'b1);
      repeat (10) tick();
      check("bp_valid",    32'(bus.out_valid),        32'd1);
      check("bp_data",     32'(bus.out_data),         32'h3C);
      check("bp_src",      32'(bus.out_src),          32'd0);
      check("bp_park_ack", 32'(bus.deser_ack_in),     32'd0);
      check("bp_park_rdy", 32'(bus.deser_data_ready), 32'd1);
      check("bp_park_gnt", 32'(bus.gnt),              32'd0);
      repeat (5) tick();
      check("bp_stable",   32'(bus.out_data),         32'h3C);
      bus.out_ready = 1'b1;
      tick();
      check("bp_reload_valid", 32'(bus.out_valid), 32'd1);
      check("bp_reload_data",  32'(bus.out_data),  32'hC3);
      wait_bytes(base + 2, 20);
      repeat (4) tick();
      check("bp_count", 32'(got_data.size() - base), 32'd2);
      check("bp_first", 32'(got_data[base]),   32'h3C);
      check("bp_second", 32'(got_data[base+1]), 32'hC3);
      check("bp_second_src", 32'(got_src[base+1]), 32'd1);

      // deserializer never presents: abort after TIMEOUT+1 cycles, keep serving
      do_reset();
      base = got_data.size();
      block_rdy = 1'b1;
      bus.req = 4'b0100;
      send_bits(2, {8'h77, 2'b00}, 8, 1'b1);
      n = 0;
      while (!bus.err_timeout && n < 60) begin
         tick();
         n++;
      end
      check("to_cycles", 32'(n), 32'(TIMEOUT + 1));
      check("to_gnt",    32'(bus.gnt), 32'd0);
      block_rdy = 1'b0;
      bus.req = 4'b1000;
      wait_gnt(3, 3);
      send_bits(3, {8'h81, 2'b00}, 8, 1'b1);
      wait_bytes(base + 1, 60);
      check("to_next_data", 32'(got_data[base]), 32'h81);
      check("to_next_src",  32'(got_src[base]),  32'd3);
      check("to_err_sticky", 32'(bus.err_timeout), 32'd1);

      // asynchronous reset in the middle of a byte
      do_reset();
      bus.out_ready = 1'b0;
      bus.req = 4'b0010;
      send_bits(1, {8'h42, 2'b00}, 8, 1'b1);
      bus.req = 4'b0100;
      send_bits(2, {8'h96, 2'b00}, 4, 1'b1);
      check("mid_gnt_pre",   32'(bus.gnt),       32'b0100);
      check("mid_valid_pre", 32'(bus.out_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_gnt",   32'(bus.gnt),          32'd0);
      check("mid_valid", 32'(bus.out_valid),    32'd0);
      check("mid_ack",   32'(bus.deser_ack_in), 32'd0);
      tick();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      base = got_data.size();
      bus.req = 4'b0100;
      send_bits(2, {8'h96, 2'b00}, 8, 1'b1);
      wait_bytes(base + 1, 60);
      check("post_rst_data", 32'(got_data[base]), 32'h96);
      check("post_rst_src",  32'(got_src[base]),  32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
